// File: rtl/cipher_cfg_pkg.sv
// Shared constants for the cipher configuration chain: chain length, field
// offsets within the 195-bit image, and the loader FSM state encoding.
package cipher_cfg_pkg;

  localparam int CFG_BITS  = 195;
  localparam int NUM_BYTES = (CFG_BITS + 7) / 8;
  localparam int PAD_BITS  = NUM_BYTES * 8;

  localparam int RX_STATE_LSB = 0;
  localparam int RX_TAPS_LSB  = 48;
  localparam int TX_STATE_LSB = 96;
  localparam int TX_TAPS_LSB  = 144;
  localparam int D_EN_BIT     = 192;
  localparam int A_MUX_BIT    = 193;
  localparam int K_MUX_BIT    = 194;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/cipher_cfg_loader.sv
// Byte-stream loader for the cipher serial config chain; shifts the new image
// in LSB first while capturing the old image for byte-wise readback.
//
// state | meaning
// FILL  | accept NUM_BYTES config bytes into buf
// SHIFT | drive cfg_en for CFG_BITS cycles, buf rotates through the cipher
// READ  | return the captured old configuration byte by byte
// DONE  | one-cycle done pulse, then back to FILL
module cipher_cfg_loader
  import cipher_cfg_pkg::*;
#(
  parameter bit READBACK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] rb_data,
  output logic       rb_valid,
  input  logic       rb_ready,
  output logic       busy,
  output logic       done,
  output logic       cfg_en,
  output logic       cfg_i,
  input  logic       cfg_o
);

  localparam logic [4:0] LAST_BYTE = 5'(NUM_BYTES - 1);
  localparam logic [7:0] LAST_BIT  = 8'(CFG_BITS - 1);

  state_t                state_q, state_d;
  logic [CFG_BITS-1:0]   buf_q, buf_d;
  logic [4:0]            byte_cnt_q, byte_cnt_d;
  logic [7:0]            bit_cnt_q, bit_cnt_d;
  logic                  cfg_en_q, busy_q;
  logic [PAD_BITS-1:0]   pad_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_FILL;
      buf_q      <= '0;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      cfg_en_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      // cfg_en/busy come straight from flops so the cipher never sees a glitch
      cfg_en_q   <= (state_d == ST_SHIFT);
      busy_q     <= (state_d == ST_SHIFT) || (state_d == ST_READ);
    end
  end

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          // the last byte only carries CFG_BITS % 8 live bits; the rest drop here
          for (int i = 0; i < CFG_BITS; i++) begin
            if (i[7:3] == byte_cnt_q) buf_d[i] = in_data[i[2:0]];
          end
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = ST_SHIFT;
          end else begin
            byte_cnt_d = byte_cnt_q + 5'd1;
          end
        end
      end
      ST_SHIFT: begin
        buf_d = {cfg_o, buf_q[CFG_BITS-1:1]};
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          state_d   = READBACK_EN ? ST_READ : ST_DONE;
        end else begin
          bit_cnt_d = bit_cnt_q + 8'd1;
        end
      end
      ST_READ: begin
        if (rb_ready) begin
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            state_d    = ST_DONE;
          end else begin
            byte_cnt_d = byte_cnt_q + 5'd1;
          end
        end
      end
      ST_DONE: begin
        byte_cnt_d = '0;
        state_d    = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
  end

  assign pad_q    = {{(PAD_BITS - CFG_BITS){1'b0}}, buf_q};
  assign in_ready = (state_q == ST_FILL);
  assign rb_valid = (state_q == ST_READ);
  assign rb_data  = rb_valid ? pad_q[{byte_cnt_q, 3'b000} +: 8] : 8'h00;
  assign done     = (state_q == ST_DONE);
  assign busy     = busy_q;
  assign cfg_en   = cfg_en_q;
  assign cfg_i    = buf_q[0];

endmodule

// File: tb/tb_cipher_cfg_loader.sv
// Directed bench for cipher_cfg_loader: two instances (readback on/off), each
// attached to a behavioural model of the cipher's serial config chain.
module tb_cipher_cfg_loader;

  localparam logic [194:0] CIP_DEF = (195'h48 << 168) | (195'h55 << 96) |
                                     (195'h48 << 72)  | 195'h55;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       rb_ready;
  logic       sel;
  logic       cip_rst;

  logic       in_ready_a, rb_valid_a, busy_a, done_a, cfg_en_a, cfg_i_a, cfg_o_a;
  logic [7:0] rb_data_a;
  logic       in_ready_b, rb_valid_b, busy_b, done_b, cfg_en_b, cfg_i_b, cfg_o_b;
  logic [7:0] rb_data_b;
  logic       in_valid_a, in_valid_b;

  logic       m_in_ready, m_rb_valid, m_busy, m_done, m_cfg_en;
  logic [7:0] m_rb_data;

  logic [194:0] cip_a, cip_b;

  int total = 0;
  int bad   = 0;
  int en_run = 0, en_last_run = 0, done_cnt = 0, rbv_cnt = 0;

  logic [7:0] tx_img [25];
  logic [7:0] rb_exp [25];

  cipher_cfg_loader #(.READBACK_EN(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .rb_data(rb_data_a), .rb_valid(rb_valid_a),
    .rb_ready(rb_ready), .busy(busy_a), .done(done_a), .cfg_en(cfg_en_a),
    .cfg_i(cfg_i_a), .cfg_o(cfg_o_a)
  );

  cipher_cfg_loader #(.READBACK_EN(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .rb_data(rb_data_b), .rb_valid(rb_valid_b),
    .rb_ready(rb_ready), .busy(busy_b), .done(done_b), .cfg_en(cfg_en_b),
    .cfg_i(cfg_i_b), .cfg_o(cfg_o_b)
  );

  assign in_valid_a = in_valid & ~sel;
  assign in_valid_b = in_valid & sel;
  assign m_in_ready = sel ? in_ready_b : in_ready_a;
  assign m_rb_valid = sel ? rb_valid_b : rb_valid_a;
  assign m_rb_data  = sel ? rb_data_b  : rb_data_a;
  assign m_busy     = sel ? busy_b     : busy_a;
  assign m_done     = sel ? done_b     : done_a;
  assign m_cfg_en   = sel ? cfg_en_b   : cfg_en_a;

  // cipher config chains: shift toward bit 0, old bit 0 leaves on cfg_o
  always @(posedge clk) begin
    if (cip_rst) cip_a <= CIP_DEF;
    else if (cfg_en_a) cip_a <= {cfg_i_a, cip_a[194:1]};
    if (cip_rst) cip_b <= CIP_DEF;
    else if (cfg_en_b) cip_b <= {cfg_i_b, cip_b[194:1]};
  end
  assign cfg_o_a = cip_a[0];
  assign cfg_o_b = cip_b[0];

  always @(posedge clk) begin
    if (m_cfg_en) en_run <= en_run + 1;
    else if (en_run != 0) begin
      en_last_run <= en_run;
      en_run      <= 0;
    end
    if (m_done) done_cnt <= done_cnt + 1;
    if (m_rb_valid) rbv_cnt <= rbv_cnt + 1;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [194:0] obs, input logic [194:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [194:0] image_bits();
    logic [199:0] t;
    for (int k = 0; k < 25; k++) t[8*k +: 8] = tx_img[k];
    return t[194:0];
  endfunction

  // feeds tx_img; returns at the negedge of shift cycle 0
  task automatic load(input bit gaps);
    for (int k = 0; k < 25; k++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      check("fill_in_ready", m_in_ready, 1);
      in_valid = 1'b1;
      in_data  = tx_img[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    check("shift_cfg_en_start", m_cfg_en, 1);
    check("shift_busy", m_busy, 1);
    check("shift_in_ready", m_in_ready, 0);
  endtask

  // drains readback against rb_exp, optionally stalling at hold_k
  task automatic readback(input int hold_k);
    int n = 0;
    while (!m_rb_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("rb_wait", m_rb_valid, 1);
    check("shift_len", n, 195);
    for (int k = 0; k < 25; k++) begin
      if (k == hold_k) begin
        rb_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          check("rb_hold", m_rb_data, rb_exp[k]);
        end
      end
      check("rb_valid", m_rb_valid, 1);
      check($sformatf("rb_byte%0d", k), m_rb_data, rb_exp[k]);
      rb_ready = 1'b1;
      @(negedge clk);
      rb_ready = 1'b0;
    end
    check("done_pulse", m_done, 1);
    check("done_busy", m_busy, 0);
    check("done_rb_valid", m_rb_valid, 0);
    @(negedge clk);
    check("done_low", m_done, 0);
    check("refill_in_ready", m_in_ready, 1);
  endtask

  initial begin
    int d0;
    int r0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; rb_ready = 1'b0;
    sel = 1'b0; cip_rst = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; cip_rst = 1'b0;

    check("rst_in_ready", in_ready_a, 1);
    check("rst_cfg_en", cfg_en_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_rb_valid", rb_valid_a, 0);
    check("rst_rb_data", rb_data_a, 0);
    check("rst_cfg_i", cfg_i_a, 0);
    check("rst_b_cfg_en", cfg_en_b, 0);

    // load 0x00..0x18 onto a freshly reset cipher
    for (int k = 0; k < 25; k++) begin
      tx_img[k] = 8'(k);
      rb_exp[k] = 8'h00;
    end
    rb_exp[0] = 8'h55; rb_exp[9] = 8'h48; rb_exp[12] = 8'h55; rb_exp[21] = 8'h48;
    d0 = done_cnt;
    load(1'b0);
    readback(-1);
    @(negedge clk);
    check("load1_cip_image", cip_a, image_bits());
    check("load1_cip_top3", cip_a[194:192], 3'b000);
    check("load1_en_len", en_last_run, 195);
    check("load1_done_once", done_cnt - d0, 1);

    // all-ones reload with gaps and a 10-cycle readback stall at byte 7
    for (int k = 0; k < 25; k++) begin
      rb_exp[k] = (k == 24) ? 8'h00 : 8'(k);
      tx_img[k] = 8'hFF;
    end
    d0 = done_cnt;
    load(1'b1);
    readback(7);
    @(negedge clk);
    check("load2_cip_ones", cip_a, {195{1'b1}});
    check("load2_en_len", en_last_run, 195);
    check("load2_done_once", done_cnt - d0, 1);

    // reset at shift cycle 100
    for (int k = 0; k < 25; k++) tx_img[k] = 8'hA5;
    load(1'b0);
    repeat (100) @(negedge clk);
    check("mid_cfg_en", cfg_en_a, 1);
    d0 = done_cnt;
    r0 = rbv_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_cfg_en", cfg_en_a, 0);
    check("mid_rst_in_ready", in_ready_a, 1);
    check("mid_rst_busy", busy_a, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_rst_idle_cfg_en", cfg_en_a, 0);
    check("mid_rst_rb_valid", rbv_cnt - r0, 0);
    check("mid_rst_no_done", done_cnt - d0, 0);

    // readback disabled instance; byte 24 = 0xFF only fills bits 194:192
    sel = 1'b1;
    for (int k = 0; k < 24; k++) tx_img[k] = 8'h3C;
    tx_img[24] = 8'hFF;
    d0 = done_cnt;
    r0 = rbv_cnt;
    load(1'b0);
    repeat (194) @(negedge clk);
    check("norb_cycle194_cfg_en", cfg_en_b, 1);
    check("norb_cycle194_done", done_b, 0);
    @(negedge clk);
    check("norb_done_pulse", done_b, 1);
    check("norb_done_cfg_en", cfg_en_b, 0);
    check("norb_done_busy", busy_b, 0);
    @(negedge clk);
    check("norb_done_low", done_b, 0);
    check("norb_in_ready", in_ready_b, 1);
    check("norb_cip", cip_b, {3'b111, {24{8'h3C}}});
    check("norb_en_len", en_last_run, 195);
    check("norb_done_once", done_cnt - d0, 1);
    check("norb_no_rb_valid", rbv_cnt - r0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
